// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared-ALU arbiter slice.
//   XLEN         : datapath width (32)
//   alu_op_e     : 4-bit ALU control codes ALU_ADD .. ALU_AND (codes 10..15
//                  are unassigned and produce a zero result)
//   out_state_e  : occupancy of the one-entry response register
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 32-bit integer ALU.
//   a, b   : operands
//   op     : 4-bit control code (alu_pkg::alu_op_e); unknown codes give 0
//   result : operation result
// Shift amounts use only b[4:0].
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      op,
  output logic [XLEN-1:0] result
);

  // One result per code; the default arm covers the unassigned codes 10..15.
  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot (or zero when no request) grant
//   idx   : binary index of the granted requester (0 when none)
// The search runs from ptr upward, wrapping modulo NREQ.
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic found;

  // Outer loop walks priority order (offset k from ptr); the inner loop maps
  // that rotated position back onto a fixed bit index so every select into
  // req/grant is by a plain loop index.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (j == ((int'(ptr) + k) % NREQ))) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU among NREQ requesters with round-robin arbitration and a
// one-entry registered response tagged with the issuing requester.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot-or-zero)
//   req_a/req_b/req_op  : per-requester operands and ALU code
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : requester that issued the held result
//   rsp_result/rsp_zero : registered result and (result == 0)
// A drain and a new grant may happen on the same edge, giving one op/cycle.
// ---------------------------------------------------------------------------
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][XLEN-1:0] req_a,
  input  logic [NREQ-1:0][XLEN-1:0] req_b,
  input  logic [NREQ-1:0][3:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [XLEN-1:0]           rsp_result,
  output logic                      rsp_zero
);

  out_state_e      state, state_next;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] arb_grant;
  logic [IDW-1:0]  gnt_idx;
  logic            can_accept;
  logic            granted;
  logic [XLEN-1:0] alu_result;

  assign rsp_valid  = (state == OUT_FULL);
  assign can_accept = !rsp_valid || rsp_ready;
  assign granted    = can_accept && (|req_valid);
  assign req_ready  = can_accept ? arb_grant : '0;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (gnt_idx)
  );

  // Operands reach the ALU only through the granted-index mux and land in
  // registers, so payload never reaches an output combinationally.
  alu u_alu (
    .a      (req_a[gnt_idx]),
    .b      (req_b[gnt_idx]),
    .op     (req_op[gnt_idx]),
    .result (alu_result)
  );

  // Response register occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // A grant always fills the register (even while draining); without a
  // grant, a taken response empties it.
  always_comb begin
    state_next = state;
    case (state)
      OUT_EMPTY: if (granted) state_next = OUT_FULL;
      OUT_FULL:  if (!granted && rsp_ready) state_next = OUT_EMPTY;
      default:   state_next = OUT_EMPTY;
    endcase
  end

  // Payload and round-robin pointer only move on a grant; after a drain the
  // last result stays visible with rsp_valid low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= '0;
      rr_ptr     <= '0;
    end else if (granted) begin
      rsp_result <= alu_result;
      rsp_zero   <= (alu_result == '0);
      rsp_id     <= gnt_idx;
      rr_ptr     <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with NREQ=2: a table of single-op
// vectors followed by hand-written contention, backpressure, illegal-op and
// async-reset sequences.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 2;

  logic                      clk;
  logic                      rst_n;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ-1:0][XLEN-1:0] req_a;
  logic [NREQ-1:0][XLEN-1:0] req_b;
  logic [NREQ-1:0][3:0]      req_op;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic [XLEN-1:0]           rsp_result;
  logic                      rsp_zero;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int unsigned who;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [1:0]  exp_ready;
    logic [31:0] exp_result;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[13];

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Full reset with the reset-state checks; releases on a falling clock edge.
  task automatic doReset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_result", rsp_result, 32'd0);
    checkOutput("reset rsp_zero", 32'(rsp_zero), 32'd0);
    checkOutput("reset rsp_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
  endtask

  // Present one op on a single requester, check the same-cycle grant, then
  // check the registered response one cycle later.
  task automatic applyStimulus(input vec_t v, input int n);
    @(negedge clk);
    req_valid        = '0;
    req_valid[v.who] = 1'b1;
    req_a[v.who]     = v.a;
    req_b[v.who]     = v.b;
    req_op[v.who]    = v.op;
    rsp_ready        = 1'b1;
    #1;
    checkOutput($sformatf("vec%0d req_ready", n), 32'(req_ready), 32'(v.exp_ready));
    @(negedge clk);
    req_valid = '0;
    checkOutput($sformatf("vec%0d rsp_valid", n), 32'(rsp_valid), 32'd1);
    checkOutput($sformatf("vec%0d rsp_result", n), rsp_result, v.exp_result);
    checkOutput($sformatf("vec%0d rsp_zero", n), 32'(rsp_zero), 32'(v.exp_zero));
    checkOutput($sformatf("vec%0d rsp_id", n), 32'(rsp_id), v.who);
  endtask

  initial begin
    vecs[0]  = '{0, 32'd5,          32'd7,          ALU_ADD,  2'b01, 32'd12,         1'b0};
    vecs[1]  = '{1, 32'd3,          32'd3,          ALU_SUB,  2'b10, 32'd0,          1'b1};
    vecs[2]  = '{0, 32'h8000_0000,  32'd4,          ALU_SRA,  2'b01, 32'hF800_0000,  1'b0};
    vecs[3]  = '{1, 32'd1,          32'h21,         ALU_SLL,  2'b10, 32'd2,          1'b0};
    vecs[4]  = '{0, 32'hFFFF_FFFF,  32'd1,          ALU_SLT,  2'b01, 32'd1,          1'b0};
    vecs[5]  = '{1, 32'hFFFF_FFFF,  32'd1,          ALU_SLTU, 2'b10, 32'd0,          1'b1};
    vecs[6]  = '{0, 32'h0000_F0F0,  32'h0000_0FF0,  ALU_XOR,  2'b01, 32'h0000_FF00,  1'b0};
    vecs[7]  = '{1, 32'h8000_0000,  32'd4,          ALU_SRL,  2'b10, 32'h0800_0000,  1'b0};
    vecs[8]  = '{0, 32'hA,          32'h5,          ALU_OR,   2'b01, 32'hF,          1'b0};
    vecs[9]  = '{1, 32'hC,          32'hA,          ALU_AND,  2'b10, 32'h8,          1'b0};
    vecs[10] = '{0, 32'd1,          32'd1,          4'hF,     2'b01, 32'd0,          1'b1};
    vecs[11] = '{1, 32'hFFFF_FFFF,  32'd1,          ALU_ADD,  2'b10, 32'd0,          1'b1};
    vecs[12] = '{0, 32'd0,          32'd1,          ALU_SUB,  2'b01, 32'hFFFF_FFFF,  1'b0};

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b1;
    doReset();

    // Table-driven single operations.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], i);
    end
    @(negedge clk);
    checkOutput("drained rsp_valid", 32'(rsp_valid), 32'd0);

    // Contention: both requesters valid every cycle, grants alternate 0,1,0,1.
    doReset();
    @(negedge clk);
    req_a[0] = 32'd3;         req_b[0] = 32'd3; req_op[0] = ALU_SUB;
    req_a[1] = 32'h8000_0000; req_b[1] = 32'd4; req_op[1] = ALU_SRA;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    checkOutput("rr first ready", 32'(req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rr%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("rr%0d rsp_id", i), 32'(rsp_id), 32'(i % 2));
      checkOutput($sformatf("rr%0d rsp_result", i), rsp_result,
                  (i % 2 == 1) ? 32'hF800_0000 : 32'd0);
      checkOutput($sformatf("rr%0d rsp_zero", i), 32'(rsp_zero),
                  (i % 2 == 1) ? 32'd0 : 32'd1);
      #1;
      checkOutput($sformatf("rr%0d next ready", i), 32'(req_ready),
                  (i % 2 == 1) ? 32'h1 : 32'h2);
    end

    // Backpressure: FULL holding requester 1's result, consumer stalls.
    rsp_ready = 1'b0;
    #1;
    checkOutput("bp ready blocked", 32'(req_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp%0d rsp_id", i), 32'(rsp_id), 32'd1);
      checkOutput($sformatf("bp%0d rsp_result", i), rsp_result, 32'hF800_0000);
      checkOutput($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp release ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    checkOutput("bp refill rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp refill rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("bp refill rsp_result", rsp_result, 32'd0);
    checkOutput("bp refill rsp_zero", 32'(rsp_zero), 32'd1);

    // Illegal op is answered and still advances the round-robin pointer.
    doReset();
    @(negedge clk);
    req_a[0] = 32'd1; req_b[0] = 32'd1; req_op[0] = 4'hF;
    req_a[1] = 32'd5; req_b[1] = 32'd7; req_op[1] = ALU_ADD;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    checkOutput("ill ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    checkOutput("ill rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("ill rsp_result", rsp_result, 32'd0);
    checkOutput("ill rsp_zero", 32'(rsp_zero), 32'd1);
    #1;
    checkOutput("ill ptr advanced", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    checkOutput("ill next rsp_id", 32'(rsp_id), 32'd1);
    checkOutput("ill next rsp_result", rsp_result, 32'd12);

    // Async reset while FULL, with rr_ptr moved to 1 beforehand.
    @(negedge clk);
    req_a[0] = 32'd5; req_b[0] = 32'd7; req_op[0] = ALU_ADD;
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = '0;
    checkOutput("ar full before", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar rsp_valid async", 32'(rsp_valid), 32'd0);
    checkOutput("ar rsp_result async", rsp_result, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    checkOutput("ar no stale rsp", 32'(rsp_valid), 32'd0);
    checkOutput("ar first grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = '0;
    checkOutput("ar new rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("ar new rsp_result", rsp_result, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter that shares one ALU instance among NREQ requesters (e.g. the main execute path, a branch/address unit and a debug/CSR path). It accepts at most one operation per cycle via per-requester valid/ready, computes it combinationally in the ALU, and holds the result in a one-entry output register tagged with the requester ID. The output register releases its result under a valid/ready handshake.

## Interface
- NREQ, 2, number of requesters (legal 2..4)
- IDW, $clog2(NREQ), width of requester ID (derived, not overridden)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NREQ  requester i presents an operation
- req_ready  out  NREQ  one-hot-or-zero grant; operation i accepted this cycle
- req_a  in  NREQ×32  operand A per requester (packed [NREQ-1:0][31:0])
- req_b  in  NREQ×32  operand B per requester
- req_op  in  NREQ×4  ALU control code per requester
- rsp_valid  out  1  output register holds a result
- rsp_ready  in  1  consumer accepts result this cycle
- rsp_id  out  IDW  index of requester that issued the result
- rsp_result  out  32  registered ALU result
- rsp_zero  out  1  registered (result == 0)

## Operation
- ALU codes: 0 ADD, 1 SUB, 2 SLL (b[4:0]), 3 SLT signed, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; codes 10–15 give result 0, zero 1, and are still accepted and answered (no error).
- Output register state: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_accept = !rsp_valid | rsp_ready.
- Grant: when can_accept, grant the first requester with req_valid set, searching from rr_ptr upward mod NREQ; req_ready[g]=1 for that one only. When !can_accept, req_ready = 0.
- On grant g: rsp_result ← ALU(req_a[g], req_b[g], req_op[g]); rsp_zero ← (result==0); rsp_id ← g; rsp_valid ← 1; rr_ptr ← (g+1) mod NREQ.
- No grant and rsp_valid & rsp_ready: rsp_valid ← 0; result/id/zero hold their last values.
- No grant and no drain: everything holds; rr_ptr unchanged.
- Requesters hold valid and payload stable until ready; arbiter does not check this. Dropping req_valid before grant is allowed (no side effect).
- Simultaneous drain and grant: new result replaces old in same edge, rsp_valid stays 1 (full throughput, one op/cycle).
- req_ready is combinational from req_valid, rsp_valid, rsp_ready, rr_ptr; no combinational path from req_a/req_b/req_op to any output.

## Timing
- Reset (rst_n=0, async): rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, rr_ptr=0; req_ready driven purely by the grant logic (EMPTY, so grant available immediately after release).
- Reset mid-operation: pending result discarded; no response is produced for it.
- Latency: grant edge → rsp_valid=1 one cycle later (1 cycle).
- Throughput: 1 op/cycle while rsp_ready=1; 0 while FULL and rsp_ready=0.
- Fairness: a continuously asserting requester waits at most NREQ-1 grants.

## Structure
- Shared package alu_pkg: 4-bit ALU code constants/enum (ALU_ADD … ALU_AND), XLEN=32.
- Sub-module rr_arbiter (NREQ, req vector, ptr in, one-hot grant + index out), combinational.
- One instance of the existing ALU module, fed by a NREQ:1 mux on the granted index.

## Test plan
- Reset then single op: req0 ADD a=5 b=7 → req_ready[0] same cycle; next cycle rsp_valid=1, rsp_result=12, rsp_id=0, rsp_zero=0.
- Contention NREQ=2, both valid every cycle, rsp_ready=1: grants alternate 0,1,0,1; req0 SUB 3-3 → result 0, zero 1; req1 SRA 0x80000000>>>4 → 0xF8000000.
- Backpressure: FULL with rsp_ready=0 for 3 cycles → req_ready=0, rsp_* stable; rsp_ready=1 → drain and new grant same cycle, rsp_valid stays 1.
- Illegal op 4'b1111 a=1 b=1 → result 0, zero 1, response produced, rr_ptr advances.
- Async reset asserted while FULL → rsp_valid drops immediately without clock; after release first grant goes to requester 0.
- Signed vs unsigned: SLT a=0xFFFFFFFF b=1 → 1; SLTU same operands → 0.
